// File: rtl/serial_adder_16bit.sv
// Nibble-serial 16-bit adder: one 4-bit ripple adder is reused over four
// cycles. The carry chains through a register between nibbles.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module serial_adder_16bit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum_out,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  nib_q;
  logic [15:0] a_q, b_q, psum_q;
  logic        carry_q;
  logic        accept;
  logic        last_nib;
  logic [3:0]  a_nib, b_nib, add_sum;
  logic        add_cout;

  assign a_nib    = a_q[{nib_q, 2'b00} +: 4];
  assign b_nib    = b_q[{nib_q, 2'b00} +: 4];
  assign last_nib = (nib_q == 2'd3);

  adder_4bit u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        // A start in the result cycle chains straight into the next operation.
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      nib_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept || (state_q == ADD && last_nib)) nib_q <= 2'd0;
      else if (state_q == ADD)                     nib_q <= nib_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      carry_q  <= 1'b0;
      psum_q   <= 16'h0000;
      sum_out  <= 16'h0000;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= carry_in;
    end else if (state_q == ADD) begin
      psum_q[{nib_q, 2'b00} +: 4] <= add_sum;
      carry_q                     <= add_cout;
      // The top nibble goes straight to the output so partials never show.
      if (last_nib) begin
        sum_out  <= {add_sum, psum_q[11:0]};
        overflow <= add_cout;
      end
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);

endmodule

// File: doc/serial_adder_16bit.md
SERIAL_ADDER_16BIT -- requirements
Module: serial_adder_16bit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low; ports SHALL be named clk and n_rst.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-006 a_in  input  16  operand A; sampled only when start is accepted.
REQ-007 b_in  input  16  operand B; sampled only when start is accepted.
REQ-008 carry_in  input  1  initial carry; sampled only when start is accepted.
REQ-009 busy  output  1  high while a nibble computation is in progress.
REQ-010 done  output  1  single-cycle pulse marking a valid result.
REQ-011 sum_out  output  16  registered final sum.
REQ-012 overflow  output  1  registered unsigned carry-out of bit 15.

Function
REQ-013 Arithmetic SHALL be performed by one instance of the team's 4-bit ripple adder (adder_4bit), reused once per nibble; no other adder logic SHALL exist in the datapath.
REQ-014 FSM states: IDLE, ADD, DONE; a 2-bit nibble index nib SHALL select the active nibble in ADD.
REQ-015 IDLE: start=1 -> latch a_in, b_in, carry_in into internal registers, nib<=0, go to ADD; start=0 -> stay IDLE.
REQ-016 ADD: each cycle, present nibble nib of latched A and B plus the carry register to the adder; store the 4-bit sum into partial-sum nibble nib; load the carry register from the adder carry-out; nib<=nib+1.
REQ-017 ADD with nib=3: after storing, copy the full partial sum to sum_out, copy the carry-out to overflow, go to DONE.
REQ-018 DONE: done=1 for exactly this one cycle; start=1 -> accepted as in IDLE (back-to-back, go to ADD); start=0 -> go to IDLE.
REQ-019 busy SHALL equal (state==ADD); done SHALL equal (state==DONE); both SHALL be decoded from registered state only.
REQ-020 Latency: start sampled at edge t0 -> busy high for cycles t0..t4 (4 cycles) -> done high for cycle t4..t5; 5 cycles from start to result.
REQ-021 start asserted while busy SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-022 Input changes on a_in/b_in/carry_in after acceptance SHALL NOT affect the result.
REQ-023 sum_out and overflow SHALL update only on the ADD(nib=3)->DONE transition and SHALL hold until the next result; partial sums SHALL never appear on sum_out.
REQ-024 nib wrap from 3 SHALL NOT occur; leaving ADD resets nib to 0.

Reset
REQ-025 n_rst low SHALL immediately force state=IDLE, nib=0, carry register=0, operand and partial-sum registers=0, sum_out=16'h0000, overflow=0, busy=0, done=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; sum_out keeps its reset value until a full new operation completes.
REQ-027 After n_rst deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-028 A=16'h1234, B=16'h4321, cin=0, start one cycle -> busy 4 cycles, done pulse on 5th cycle, sum_out=16'h5555, overflow=0.
REQ-029 A=16'hFFFF, B=16'h0001, cin=0 -> sum_out=16'h0000, overflow=1 (carry ripples through all four nibbles).
REQ-030 A=16'h0000, B=16'h0000, cin=1 -> sum_out=16'h0001, overflow=0; A=16'h8000, B=16'h8000, cin=1 -> sum_out=16'h0001, overflow=1.
REQ-031 Start 16'h00FF+16'h0001, then pulse start with A=16'h1111 during cycle 2 of busy -> ignored; result 16'h0100, overflow=0, exactly one done pulse.
REQ-032 Start 16'hF0F0+16'h0F0F, n_rst low during 3rd busy cycle -> all outputs 0 immediately, no done; new 16'h0002+16'h0003 -> sum_out=16'h0005.
REQ-033 Hold start=1 with 16'h0001+16'h0001, then 16'h7FFF+16'h0001 presented in the DONE cycle -> first done shows 16'h0002, second op begins with no idle cycle, second done shows 16'h8000, overflow=0.
